// File: rtl/sine_sum_dac_spi.sv
// Scales a 13-bit sine sum to 12 bits and sends it to a 12-bit SPI DAC as a
// 16-bit {command, code} frame, counting samples offered while the link is busy.
`timescale 1ns/1ps
module sine_sum_dac_spi #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2,
  parameter logic [3:0]  DAC_CMD = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        busy,
  output logic [7:0]  skip_cnt
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            r_state, w_state_d;
  logic [15:0]       r_shift, w_shift_d;
  logic [DivW-1:0]   r_div, w_div_d;
  logic [3:0]        r_bit, w_bit_d;
  logic [GapW-1:0]   r_gap, w_gap_d;
  logic              r_cs_n, w_cs_n_d;
  logic              r_sclk, w_sclk_d;
  logic              r_sdi, w_sdi_d;
  logic              r_ready, w_ready_d;
  logic              r_busy;
  logic [7:0]        r_skip, w_skip_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdi   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_div   <= w_div_d;
      r_bit   <= w_bit_d;
      r_gap   <= w_gap_d;
      r_cs_n  <= w_cs_n_d;
      r_sclk  <= w_sclk_d;
      r_sdi   <= w_sdi_d;
      r_ready <= w_ready_d;
      r_busy  <= ~w_ready_d;
      r_skip  <= w_skip_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_div_d   = r_div;
    w_bit_d   = r_bit;
    w_gap_d   = r_gap;
    w_cs_n_d  = r_cs_n;
    w_sclk_d  = r_sclk;
    w_sdi_d   = r_sdi;
    w_ready_d = r_ready;
    w_skip_d  = r_skip;

    if (sample_valid && !r_ready && (r_skip != 8'hFF)) begin
      w_skip_d = r_skip + 8'd1;
    end

    unique case (r_state)
      StIdle: begin
        if (sample_valid) begin
          w_shift_d = {DAC_CMD, sample_in[12:1]};
          w_sdi_d   = DAC_CMD[3];
          w_cs_n_d  = 1'b0;
          w_sclk_d  = 1'b0;
          w_div_d   = '0;
          w_bit_d   = '0;
          w_ready_d = 1'b0;
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (r_div == DivLast) begin
          w_div_d  = '0;
          w_sclk_d = ~r_sclk;
          // End of a high half-period: advance to the next bit or close the frame.
          if (r_sclk) begin
            if (r_bit == 4'd15) begin
              w_state_d = StGap;
              w_cs_n_d  = 1'b1;
              w_sclk_d  = 1'b0;
              w_sdi_d   = 1'b0;
              w_gap_d   = '0;
            end else begin
              w_bit_d   = r_bit + 4'd1;
              w_shift_d = {r_shift[14:0], 1'b0};
              w_sdi_d   = r_shift[14];
            end
          end
        end else begin
          w_div_d = r_div + DivW'(1);
        end
      end
      StGap: begin
        if (r_gap == GapLast) begin
          w_state_d = StIdle;
          w_ready_d = 1'b1;
        end else begin
          w_gap_d = r_gap + GapW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cs_n_d  = 1'b1;
        w_sclk_d  = 1'b0;
        w_sdi_d   = 1'b0;
        w_ready_d = 1'b1;
      end
    endcase
  end

  assign sample_ready = r_ready;
  assign busy         = r_busy;
  assign dac_cs_n     = r_cs_n;
  assign dac_sclk     = r_sclk;
  assign dac_sdi      = r_sdi;
  assign skip_cnt     = r_skip;

endmodule
